pulse_cut_ctrl: RTL and testbench



---
 rtl/pulse_cut_ctrl.sv | 138 +++++++++++++
 tb/tb_pulse_cut_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cut_ctrl.sv
// Arming / cut / lockout sequencer for the pulse-match detector.
// Owns the detector reset and config, fires a timed cut on flag_cut.
module pulse_cut_ctrl #(
   parameter int unsigned THRESHOLD_DEF = 25,
   parameter int unsigned ERRO_RATE_DEF = 10,
   parameter int unsigned SETTLE        = 4,
   parameter int unsigned CUT_HOLD      = 8,
   parameter int unsigned LOCKOUT       = 16,
   parameter int unsigned ARM_TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arm,
   input  logic        disarm,
   input  logic        auto_rearm,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [11:0] cfg_threshold,
   input  logic [4:0]  cfg_erro_rate,
   input  logic        flag_cut,
   input  logic [15:0] energy_pulse_width,
   output logic        det_rst,
   output logic [11:0] threshold_out,
   output logic [4:0]  erro_rate_out,
   output logic        cut_out,
   output logic        busy,
   output logic [2:0]  state_out,
   output logic [7:0]  cut_count,
   output logic [15:0] last_width,
   output logic        timeout_flag
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARMING   = 3'd1,
      S_ARMED    = 3'd2,
      S_CUT      = 3'd3,
      S_COOLDOWN = 3'd4
   } state_e;

   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE - 1);
   localparam logic [15:0] CUT_LAST     = 16'(CUT_HOLD - 1);
   localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(ARM_TIMEOUT - 1);
   localparam logic        TIMEOUT_EN   = (ARM_TIMEOUT != 0);

   state_e      state_q;
   logic [15:0] timer_q;
   logic [11:0] thr_q;
   logic [4:0]  rate_q;
   logic [7:0]  cnt_q;
   logic [15:0] width_q;
   logic        tflag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         thr_q   <= 12'(THRESHOLD_DEF);
         rate_q  <= 5'(ERRO_RATE_DEF);
         cnt_q   <= '0;
         width_q <= '0;
         tflag_q <= 1'b0;
      end else begin
         // Config is only accepted while the detector is parked in IDLE.
         if (cfg_valid && state_q == S_IDLE) begin
            thr_q  <= cfg_threshold;
            rate_q <= cfg_erro_rate;
         end
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  state_q <= S_ARMING;
                  timer_q <= '0;
                  tflag_q <= 1'b0;
               end
            end
            S_ARMING: begin
               if (disarm) begin
                  state_q <= S_IDLE;
               end else if (timer_q == SETTLE_LAST) begin
                  state_q <= S_ARMED;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            S_ARMED: begin
               if (disarm) begin
                  state_q <= S_IDLE;
               end else if (flag_cut) begin
                  state_q <= S_CUT;
                  timer_q <= '0;
                  width_q <= energy_pulse_width;
                  if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
               end else if (TIMEOUT_EN && timer_q == TIMEOUT_LAST) begin
                  state_q <= S_IDLE;
                  tflag_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            S_CUT: begin
               // A started cut always runs to completion.
               if (timer_q == CUT_LAST) begin
                  state_q <= S_COOLDOWN;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            S_COOLDOWN: begin
               if (disarm) begin
                  state_q <= S_IDLE;
               end else if (timer_q == LOCKOUT_LAST) begin
                  state_q <= auto_rearm ? S_ARMING : S_IDLE;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cfg_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign det_rst       = (state_q != S_ARMED);
   assign cut_out       = (state_q == S_CUT);
   assign state_out     = state_q;
   assign threshold_out = thr_q;
   assign erro_rate_out = rate_q;
   assign cut_count     = cnt_q;
   assign last_width    = width_q;
   assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_pulse_cut_ctrl.sv
// Bench for pulse_cut_ctrl: phase/countdown model compared every cycle,
// plus literal expectations from directed scenarios.
module tb_pulse_cut_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm = 0, disarm = 0, auto_rearm = 0, cfg_valid = 0, flag_cut = 0;
   logic [11:0] cfg_threshold = '0;
   logic [4:0]  cfg_erro_rate = '0;
   logic [15:0] energy_pulse_width = '0;
   logic        cfg_ready, det_rst, cut_out, busy, timeout_flag;
   logic [11:0] threshold_out;
   logic [4:0]  erro_rate_out;
   logic [2:0]  state_out;
   logic [7:0]  cut_count;
   logic [15:0] last_width;

   logic        rst0_n = 1'b0, arm0 = 1'b0, zero = 1'b0;
   logic        cfg_ready0, det_rst0, cut_out0, busy0, tflag0;
   logic [11:0] thr0;
   logic [4:0]  rate0;
   logic [2:0]  state0;
   logic [7:0]  cnt0;
   logic [15:0] width0;

   int checks = 0;
   int errors = 0;
   int cut_hi = 0;

   always #5 clk = ~clk;

   pulse_cut_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .auto_rearm(auto_rearm),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_threshold(cfg_threshold),
      .cfg_erro_rate(cfg_erro_rate), .flag_cut(flag_cut),
      .energy_pulse_width(energy_pulse_width), .det_rst(det_rst),
      .threshold_out(threshold_out), .erro_rate_out(erro_rate_out), .cut_out(cut_out),
      .busy(busy), .state_out(state_out), .cut_count(cut_count),
      .last_width(last_width), .timeout_flag(timeout_flag));

   pulse_cut_ctrl #(.ARM_TIMEOUT(0)) u_dut0 (
      .clk(clk), .rst_n(rst0_n), .arm(arm0), .disarm(zero), .auto_rearm(zero),
      .cfg_valid(zero), .cfg_ready(cfg_ready0), .cfg_threshold(12'd0),
      .cfg_erro_rate(5'd0), .flag_cut(zero), .energy_pulse_width(16'd0),
      .det_rst(det_rst0), .threshold_out(thr0), .erro_rate_out(rate0), .cut_out(cut_out0),
      .busy(busy0), .state_out(state0), .cut_count(cnt0), .last_width(width0),
      .timeout_flag(tflag0));

   // Model: phase plus a countdown of cycles remaining in that phase.
   localparam int P_IDLE = 0, P_ARMING = 1, P_ARMED = 2, P_CUT = 3, P_COOL = 4;
   int m_phase, m_left, m_age, m_thr, m_rate, m_cnt, m_width, m_tflag;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_IDLE; m_left = 0; m_age = 0;
         m_thr = 25; m_rate = 10; m_cnt = 0; m_width = 0; m_tflag = 0;
      end else begin
         if (m_phase == P_IDLE && cfg_valid) begin
            m_thr = cfg_threshold; m_rate = cfg_erro_rate;
         end
         case (m_phase)
            P_IDLE: if (arm) begin m_phase = P_ARMING; m_left = 4; m_tflag = 0; end
            P_ARMING: begin
               if (disarm) m_phase = P_IDLE;
               else begin
                  m_left--;
                  if (m_left == 0) begin m_phase = P_ARMED; m_age = 0; end
               end
            end
            P_ARMED: begin
               if (disarm) m_phase = P_IDLE;
               else if (flag_cut) begin
                  m_phase = P_CUT; m_left = 8; m_width = energy_pulse_width;
                  m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
               end else begin
                  m_age++;
                  if (m_age == 1000) begin m_phase = P_IDLE; m_tflag = 1; end
               end
            end
            P_CUT: begin
               m_left--;
               if (m_left == 0) begin m_phase = P_COOL; m_left = 16; end
            end
            default: begin
               if (disarm) m_phase = P_IDLE;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = auto_rearm ? P_ARMING : P_IDLE;
                     m_left = 4;
                  end
               end
            end
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("state_out", int'(state_out), m_phase);
      chk("det_rst", int'(det_rst), (m_phase != P_ARMED) ? 1 : 0);
      chk("cut_out", int'(cut_out), (m_phase == P_CUT) ? 1 : 0);
      chk("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
      chk("cfg_ready", int'(cfg_ready), (m_phase == P_IDLE) ? 1 : 0);
      chk("threshold_out", int'(threshold_out), m_thr);
      chk("erro_rate_out", int'(erro_rate_out), m_rate);
      chk("cut_count", int'(cut_count), m_cnt);
      chk("last_width", int'(last_width), m_width);
      chk("timeout_flag", int'(timeout_flag), m_tflag);
      if (cut_out) cut_hi++;
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Timeout-disabled instance: must sit in ARMED indefinitely.
   initial begin
      #22 rst0_n = 1'b1;
      step();
      arm0 = 1'b1; step(); arm0 = 1'b0;
      step(5000);
      chk("noto_state", int'(state0), 2);
      chk("noto_det_rst", int'(det_rst0), 0);
      chk("noto_tflag", int'(tflag0), 0);
   end

   initial begin
      int found;
      #12;
      chk("rst_state", int'(state_out), 0);
      chk("rst_det_rst", int'(det_rst), 1);
      chk("rst_thr", int'(threshold_out), 25);
      chk("rst_rate", int'(erro_rate_out), 10);
      chk("rst_cnt", int'(cut_count), 0);
      #10 rst_n = 1'b1;
      step();

      // Config in IDLE
      cfg_valid = 1; cfg_threshold = 12'd100; cfg_erro_rate = 5'd5;
      chk("cfg_ready_idle", int'(cfg_ready), 1);
      step(); cfg_valid = 0;
      chk("cfg_thr", int'(threshold_out), 100);
      chk("cfg_rate", int'(erro_rate_out), 5);

      // Arm latency
      arm = 1; step(); arm = 0;
      for (int i = 0; i < 4; i++) begin
         chk("arming_state", int'(state_out), 1);
         chk("arming_det_rst", int'(det_rst), 1);
         step();
      end
      chk("armed_state", int'(state_out), 2);
      chk("armed_det_rst", int'(det_rst), 0);

      // Config ignored while armed
      cfg_valid = 1; cfg_threshold = 12'd200; cfg_erro_rate = 5'd7;
      chk("cfg_ready_armed", int'(cfg_ready), 0);
      step(); cfg_valid = 0;
      chk("cfg_thr_kept", int'(threshold_out), 100);
      chk("cfg_rate_kept", int'(erro_rate_out), 5);

      // Cut, no auto rearm
      cut_hi = 0;
      flag_cut = 1; energy_pulse_width = 16'd750; step(); flag_cut = 0;
      step(30);
      chk("cut_len", cut_hi, 8);
      chk("cut_width", int'(last_width), 750);
      chk("cut_cnt1", int'(cut_count), 1);
      chk("cut_idle", int'(state_out), 0);
      chk("cut_busy", int'(busy), 0);

      // Cut with auto rearm
      auto_rearm = 1;
      arm = 1; step(); arm = 0; step(4);
      flag_cut = 1; energy_pulse_width = 16'd300; step(); flag_cut = 0;
      step(24);
      chk("rearm_arming", int'(state_out), 1);
      step(4);
      chk("rearm_armed", int'(state_out), 2);
      auto_rearm = 0;
      disarm = 1; step(); disarm = 0;
      chk("disarm_armed", int'(state_out), 0);

      // Timeout
      arm = 1; step(); arm = 0;
      step(1010);
      chk("to_state", int'(state_out), 0);
      chk("to_flag", int'(timeout_flag), 1);
      arm = 1; step(); arm = 0;
      chk("to_flag_clr", int'(timeout_flag), 0);
      step(4);

      // disarm beats flag_cut
      disarm = 1; flag_cut = 1; step(); disarm = 0; flag_cut = 0;
      chk("dis_flag_state", int'(state_out), 0);
      chk("dis_flag_cut", int'(cut_out), 0);
      chk("dis_flag_cnt", int'(cut_count), 2);

      // disarm ignored in CUT, flag ignored in COOLDOWN, disarm honoured there
      arm = 1; step(); arm = 0; step(4);
      cut_hi = 0;
      flag_cut = 1; step(); flag_cut = 0;
      disarm = 1; step(); disarm = 0;
      step(7);
      chk("cool_state", int'(state_out), 4);
      flag_cut = 1; step(); flag_cut = 0;
      step();
      disarm = 1; step(); disarm = 0;
      chk("cool_dis_state", int'(state_out), 0);
      chk("cut_len_dis", cut_hi, 8);
      chk("cut_cnt3", int'(cut_count), 3);

      // Saturation, then async reset mid-cut
      auto_rearm = 1; flag_cut = 1; energy_pulse_width = 16'd42;
      arm = 1; step(); arm = 0;
      step(260 * 29);
      chk("sat_cnt", int'(cut_count), 255);
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (state_out == 3'd3) found = 1;
         else step();
      end
      chk("cut_found", found, 1);
      step(2);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cut", int'(cut_out), 0);
      chk("ar_det_rst", int'(det_rst), 1);
      chk("ar_thr", int'(threshold_out), 25);
      chk("ar_rate", int'(erro_rate_out), 10);
      chk("ar_cnt", int'(cut_count), 0);
      chk("ar_state", int'(state_out), 0);
      flag_cut = 0; auto_rearm = 0;
      step(2);
      rst_n = 1'b1;
      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
